// File: rtl/mag_cmp_seq.sv
// Sequential magnitude comparator: walks W-bit operands S bits per cycle, MSB slice first,
// stops on the first unequal slice and reports A>B / A==B / A<B plus a mode-selected relation.
module mag_cmp_seq #(
    parameter int W = 6,
    parameter int S = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sgn,
    input  logic [1:0]   mode,
    output logic         ready,
    output logic         done,
    output logic         result,
    output logic         agtb,
    output logic         aeqb,
    output logic         altb
);

    localparam int N  = W / S;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int NP = 1 << IW;

    generate
        if (W < 2 || S < 1 || S > W || (W % S) != 0) begin : g_param_check
            $error("mag_cmp_seq: need W >= 2, 1 <= S <= W and W divisible by S");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [1:0]      mode_q, mode_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            agtb_q, agtb_d;
    logic            aeqb_q, aeqb_d;
    logic            altb_q, altb_d;
    logic            result_q, result_d;

    // Slice table padded to a power of two so idx can address it without a range check.
    logic [S-1:0]    a_sl [NP];
    logic [S-1:0]    b_sl [NP];
    logic [S-1:0]    a_cur;
    logic [S-1:0]    b_cur;
    logic            finish;
    logic            fin_gt;
    logic            fin_eq;

    for (genvar i = 0; i < NP; i++) begin : g_slice
        if (i < N) begin : g_real
            assign a_sl[i] = a_q[i*S +: S];
            assign b_sl[i] = b_q[i*S +: S];
        end else begin : g_pad
            assign a_sl[i] = '0;
            assign b_sl[i] = '0;
        end
    end

    assign a_cur = a_sl[idx_q];
    assign b_cur = b_sl[idx_q];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        agtb_d   = agtb_q;
        aeqb_d   = aeqb_q;
        altb_d   = altb_q;
        result_d = result_q;
        finish   = 1'b0;
        fin_gt   = 1'b0;
        fin_eq   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Flipping both sign bits maps two's-complement order onto unsigned order.
                    a_d     = {a[W-1] ^ sgn, a[W-2:0]};
                    b_d     = {b[W-1] ^ sgn, b[W-2:0]};
                    mode_d  = mode;
                    idx_d   = IW'(N - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (a_cur != b_cur) begin
                    finish = 1'b1;
                    fin_gt = (a_cur > b_cur);
                end else if (idx_q == '0) begin
                    finish = 1'b1;
                    fin_eq = 1'b1;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish) begin
            state_d = DONE;
            agtb_d  = fin_gt;
            aeqb_d  = fin_eq;
            altb_d  = ~fin_gt & ~fin_eq;
            case (mode_q)
                2'b00:   result_d = fin_gt | fin_eq;
                2'b01:   result_d = fin_gt;
                2'b10:   result_d = fin_eq;
                default: result_d = ~fin_eq;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            idx_q    <= '0;
            agtb_q   <= 1'b0;
            aeqb_q   <= 1'b0;
            altb_q   <= 1'b0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            agtb_q   <= agtb_d;
            aeqb_q   <= aeqb_d;
            altb_q   <= altb_d;
            result_q <= result_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign agtb   = agtb_q;
    assign aeqb   = aeqb_q;
    assign altb   = altb_q;

endmodule

// File: tb/tb_mag_cmp_seq.sv
// Scoreboard bench for mag_cmp_seq: six instances (W=6 with S=1/2/3/6, W=8 with S=4/8)
// share operand buses; expected flags and latency come from an integer reference model.
module tb_mag_cmp_seq;

   localparam int NI = 6;
   localparam int WS [NI] = '{6, 6, 6, 6, 8, 8};
   localparam int SS [NI] = '{1, 2, 3, 6, 4, 8};

   typedef struct {
      logic gt;
      logic eq;
      logic lt;
      logic res;
      int   lat;
      int   c0;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       sgn;
   logic [1:0] mode;
   logic       start_v  [NI];
   logic       ready_v  [NI];
   logic       done_v   [NI];
   logic       result_v [NI];
   logic       agtb_v   [NI];
   logic       aeqb_v   [NI];
   logic       altb_v   [NI];

   exp_t sbq [NI][$];
   exp_t last [NI];
   int   cyc;
   int   checks;
   int   errors;

   mag_cmp_seq #(.W(6), .S(1)) u0 (.clk(clk), .reset(reset), .start(start_v[0]), .a(a8[5:0]), .b(b8[5:0]),
      .sgn(sgn), .mode(mode), .ready(ready_v[0]), .done(done_v[0]), .result(result_v[0]),
      .agtb(agtb_v[0]), .aeqb(aeqb_v[0]), .altb(altb_v[0]));
   mag_cmp_seq #(.W(6), .S(2)) u1 (.clk(clk), .reset(reset), .start(start_v[1]), .a(a8[5:0]), .b(b8[5:0]),
      .sgn(sgn), .mode(mode), .ready(ready_v[1]), .done(done_v[1]), .result(result_v[1]),
      .agtb(agtb_v[1]), .aeqb(aeqb_v[1]), .altb(altb_v[1]));
   mag_cmp_seq #(.W(6), .S(3)) u2 (.clk(clk), .reset(reset), .start(start_v[2]), .a(a8[5:0]), .b(b8[5:0]),
      .sgn(sgn), .mode(mode), .ready(ready_v[2]), .done(done_v[2]), .result(result_v[2]),
      .agtb(agtb_v[2]), .aeqb(aeqb_v[2]), .altb(altb_v[2]));
   mag_cmp_seq #(.W(6), .S(6)) u3 (.clk(clk), .reset(reset), .start(start_v[3]), .a(a8[5:0]), .b(b8[5:0]),
      .sgn(sgn), .mode(mode), .ready(ready_v[3]), .done(done_v[3]), .result(result_v[3]),
      .agtb(agtb_v[3]), .aeqb(aeqb_v[3]), .altb(altb_v[3]));
   mag_cmp_seq #(.W(8), .S(4)) u4 (.clk(clk), .reset(reset), .start(start_v[4]), .a(a8), .b(b8),
      .sgn(sgn), .mode(mode), .ready(ready_v[4]), .done(done_v[4]), .result(result_v[4]),
      .agtb(agtb_v[4]), .aeqb(aeqb_v[4]), .altb(altb_v[4]));
   mag_cmp_seq #(.W(8), .S(8)) u5 (.clk(clk), .reset(reset), .start(start_v[5]), .a(a8), .b(b8),
      .sgn(sgn), .mode(mode), .ready(ready_v[5]), .done(done_v[5]), .result(result_v[5]),
      .agtb(agtb_v[5]), .aeqb(aeqb_v[5]), .altb(altb_v[5]));

   // Free-running clock and a cycle counter used to measure request-to-done latency.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Hard stop in case the stimulus process itself wedges.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int k, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("[TB] FAIL %s inst%0d (W=%0d S=%0d): got %0d expected %0d", name, k, WS[k], SS[k], act, expv);
      end
   endtask

   // Reference: compare the operands as plain integers; latency is how many slices
   // from the top are examined until the first one that differs.
   function automatic exp_t refModel(input int k, input logic [7:0] av8, input logic [7:0] bv8,
                                     input logic sg, input logic [1:0] md);
      exp_t e;
      int w, s, n, av, bv, va, vb, smask;
      bit found;
      w = WS[k];
      s = SS[k];
      n = w / s;
      smask = (1 << s) - 1;
      av = int'(av8) & ((1 << w) - 1);
      bv = int'(bv8) & ((1 << w) - 1);
      va = (sg && ((av >> (w - 1)) & 1) == 1) ? av - (1 << w) : av;
      vb = (sg && ((bv >> (w - 1)) & 1) == 1) ? bv - (1 << w) : bv;
      e.gt = (va > vb);
      e.eq = (va == vb);
      e.lt = (va < vb);
      case (md)
         2'b00:   e.res = (va >= vb);
         2'b01:   e.res = (va > vb);
         2'b10:   e.res = (va == vb);
         default: e.res = (va != vb);
      endcase
      e.lat = n;
      found = 1'b0;
      for (int j = n - 1; j >= 0; j--) begin
         if (!found && (((av >> (j * s)) & smask) != ((bv >> (j * s)) & smask))) begin
            e.lat = n - j;
            found = 1'b1;
         end
      end
      e.c0 = 0;
      return e;
   endfunction

   function automatic bit allReady();
      bit r = 1'b1;
      for (int k = 0; k < NI; k++) if (ready_v[k] !== 1'b1) r = 1'b0;
      return r;
   endfunction

   function automatic int flagsOf(input int k);
      return int'({agtb_v[k], aeqb_v[k], altb_v[k], result_v[k]});
   endfunction

   // Monitor: on done, pop and compare flags and latency; otherwise flags must hold.
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < NI; k++) begin
         if (done_v[k] === 1'b1) begin
            if (sbq[k].size() == 0) begin
               checkOutput("unexpected_done", k, 1, 0);
            end else begin
               e = sbq[k].pop_front();
               checkOutput("agtb", k, agtb_v[k], e.gt);
               checkOutput("aeqb", k, aeqb_v[k], e.eq);
               checkOutput("altb", k, altb_v[k], e.lt);
               checkOutput("result", k, result_v[k], e.res);
               checkOutput("latency", k, cyc - e.c0, e.lat);
               last[k] = e;
            end
         end else begin
            checkOutput("flags_hold", k, flagsOf(k), int'({last[k].gt, last[k].eq, last[k].lt, last[k].res}));
         end
      end
   end

   task automatic waitAllReady();
      int t = 0;
      while (!allReady() && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!allReady()) checkOutput("ready_timeout", 0, 0, 1);
   endtask

   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic sg, input logic [1:0] md);
      exp_t e;
      waitAllReady();
      a8 = av;
      b8 = bv;
      sgn = sg;
      mode = md;
      for (int k = 0; k < NI; k++) start_v[k] = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         start_v[k] = 1'b0;
         e = refModel(k, av, bv, sg, md);
         e.c0 = cyc;
         sbq[k].push_back(e);
      end
   endtask

   task automatic checkResetState(input string tag);
      for (int k = 0; k < NI; k++) begin
         checkOutput({tag, "_ready"}, k, ready_v[k], 1);
         checkOutput({tag, "_done"}, k, done_v[k], 0);
         checkOutput({tag, "_flags"}, k, flagsOf(k), 0);
      end
   endtask

   initial begin
      exp_t e;
      logic [7:0] ra, rb;
      int t;
      checks = 0;
      errors = 0;
      cyc = 0;
      reset = 1'b1;
      a8 = '0;
      b8 = '0;
      sgn = 1'b0;
      mode = 2'b00;
      for (int k = 0; k < NI; k++) begin
         start_v[k] = 1'b0;
         last[k] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
      end
      #13;
      checkResetState("reset");
      reset = 1'b0;

      // Directed cases: early MSB difference, equal operands under several modes, signedness.
      applyStimulus(8'h30, 8'h20, 1'b0, 2'b00);
      applyStimulus(8'd37, 8'd37, 1'b0, 2'b00);
      applyStimulus(8'd37, 8'd37, 1'b0, 2'b01);
      applyStimulus(8'd37, 8'd37, 1'b0, 2'b11);
      applyStimulus(8'h3F, 8'h01, 1'b1, 2'b00);
      applyStimulus(8'h3F, 8'h01, 1'b0, 2'b00);

      // Start pulses on one instance while it is busy must be ignored.
      applyStimulus(8'h02, 8'h01, 1'b0, 2'b01);
      for (int p = 0; p < 3; p++) begin
         start_v[1] = 1'b1;
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         @(posedge clk);
         #1;
      end
      start_v[1] = 1'b0;

      // Reset in the middle of a compare aborts it with no done.
      applyStimulus(8'd37, 8'd37, 1'b0, 2'b00);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      for (int k = 0; k < NI; k++) begin
         sbq[k].delete();
         last[k] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
      end
      checkResetState("midreset");
      @(posedge clk);
      #2;
      reset = 1'b0;

      applyStimulus(8'h80, 8'h7F, 1'b1, 2'b00);
      applyStimulus(8'h80, 8'h7F, 1'b0, 2'b00);

      // start held high on the single-slice instance is re-accepted every third edge.
      waitAllReady();
      a8 = 8'h15;
      b8 = 8'h2A;
      sgn = 1'b1;
      mode = 2'b01;
      start_v[3] = 1'b1;
      for (int q = 0; q < 7; q++) begin
         @(posedge clk);
         #1;
         if (q % 3 == 0) begin
            e = refModel(3, 8'h15, 8'h2A, 1'b1, 2'b01);
            e.c0 = cyc;
            sbq[3].push_back(e);
         end
      end
      start_v[3] = 1'b0;

      // Random sweep, biased towards equal or nearly equal operands.
      for (int r = 0; r < 300; r++) begin
         ra = 8'($urandom);
         case ($urandom_range(0, 2))
            0:       rb = 8'($urandom);
            1:       rb = ra;
            default: rb = ra ^ (8'd1 << $urandom_range(0, 7));
         endcase
         applyStimulus(ra, rb, 1'($urandom), 2'($urandom));
      end

      t = 0;
      while (t < 100) begin
         @(posedge clk);
         t++;
      end
      for (int k = 0; k < NI; k++) checkOutput("missing_done", k, sbq[k].size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
